// File: rtl/tomasulo_reg_status_file.sv
// Architectural register file with Tomasulo producer (Qi) tags, issue renaming and CDB retire.
// Optional same-cycle CDB-to-read-port forwarding is enabled by defining CDB_BYPASS_EN.
module tomasulo_reg_status_file #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int TAG_W    = 3
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic [ADDR_W-1:0] rd_addr_a_i,
  output logic [DATA_W-1:0] rd_data_a_o,
  output logic [TAG_W-1:0]  rd_tag_a_o,
  input  logic [ADDR_W-1:0] rd_addr_b_i,
  output logic [DATA_W-1:0] rd_data_b_o,
  output logic [TAG_W-1:0]  rd_tag_b_o,
  input  logic              issue_valid_i,
  input  logic [ADDR_W-1:0] issue_dst_i,
  input  logic [TAG_W-1:0]  issue_tag_i,
  input  logic              cdb_valid_i,
  input  logic [TAG_W-1:0]  cdb_tag_i,
  input  logic [DATA_W-1:0] cdb_data_i,
  input  logic              flush_i,
  output logic [ADDR_W:0]   busy_count_o
);

  logic [DATA_W-1:0]   data_arr [NUM_REGS];
  logic [TAG_W-1:0]    tag_arr  [NUM_REGS];
  logic [NUM_REGS-1:0] busy_vec;
  logic [ADDR_W:0]     busy_q, busy_d;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign data_arr[gi] = '0;
        assign tag_arr[gi]  = '0;
        assign busy_vec[gi] = 1'b0;
      end else begin : g_live
        logic [DATA_W-1:0] data_q, data_d;
        logic [TAG_W-1:0]  tag_q, tag_d;
        logic              cdb_hit, issue_hit;

        assign cdb_hit   = cdb_valid_i && (cdb_tag_i != '0) && (tag_q == cdb_tag_i);
        assign issue_hit = issue_valid_i && (issue_tag_i != '0) && (issue_dst_i == ADDR_W'(gi));

        // Order matters: CDB retires, a same-cycle rename wins the tag, flush beats both.
        always_comb begin
          data_d = data_q;
          tag_d  = tag_q;
          if (cdb_hit) begin
            data_d = cdb_data_i;
            tag_d  = '0;
          end
          if (flush_i)        tag_d = '0;
          else if (issue_hit) tag_d = issue_tag_i;
        end

        always_ff @(posedge clock_i) begin
          if (!reset_n_i) begin
            data_q <= '0;
            tag_q  <= '0;
          end else begin
            data_q <= data_d;
            tag_q  <= tag_d;
          end
        end

        assign data_arr[gi] = data_q;
        assign tag_arr[gi]  = tag_q;
        assign busy_vec[gi] = |tag_d;
      end
    end
  endgenerate

  always_comb begin
    busy_d = '0;
    for (int i = 0; i < NUM_REGS; i++) busy_d = busy_d + (ADDR_W + 1)'(busy_vec[i]);
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) busy_q <= '0;
    else            busy_q <= busy_d;
  end

  assign busy_count_o = busy_q;

  always_comb begin
    rd_data_a_o = data_arr[rd_addr_a_i];
    rd_tag_a_o  = tag_arr[rd_addr_a_i];
    rd_data_b_o = data_arr[rd_addr_b_i];
    rd_tag_b_o  = tag_arr[rd_addr_b_i];
`ifdef CDB_BYPASS_EN
    // R0 never matches since its tag is zero and a zero CDB tag is ignored.
    if (cdb_valid_i && (cdb_tag_i != '0) && (tag_arr[rd_addr_a_i] == cdb_tag_i)) begin
      rd_data_a_o = cdb_data_i;
      rd_tag_a_o  = '0;
    end
    if (cdb_valid_i && (cdb_tag_i != '0) && (tag_arr[rd_addr_b_i] == cdb_tag_i)) begin
      rd_data_b_o = cdb_data_i;
      rd_tag_b_o  = '0;
    end
`endif
  end

endmodule

// File: tb/tb_tomasulo_reg_status_file.sv
// Self-checking bench: directed vector table, bypass/flush sequences, then random stimulus vs a model.
module tb_tomasulo_reg_status_file;
  localparam int DATA_W = 16, NUM_REGS = 8, ADDR_W = 3, TAG_W = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] rd_addr_a, rd_addr_b, issue_dst;
  logic [DATA_W-1:0] rd_data_a, rd_data_b, cdb_data;
  logic [TAG_W-1:0]  rd_tag_a, rd_tag_b, issue_tag, cdb_tag;
  logic              issue_valid, cdb_valid, flush;
  logic [ADDR_W:0]   busy_count;

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Reference state: plain arrays updated by the documented rules.
  logic [DATA_W-1:0] m_data [NUM_REGS];
  logic [TAG_W-1:0]  m_tag  [NUM_REGS];
  int                m_busy;

  tomasulo_reg_status_file #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .TAG_W(TAG_W)) dut (
    .clock_i(clk), .reset_n_i(rst_n),
    .rd_addr_a_i(rd_addr_a), .rd_data_a_o(rd_data_a), .rd_tag_a_o(rd_tag_a),
    .rd_addr_b_i(rd_addr_b), .rd_data_b_o(rd_data_b), .rd_tag_b_o(rd_tag_b),
    .issue_valid_i(issue_valid), .issue_dst_i(issue_dst), .issue_tag_i(issue_tag),
    .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag), .cdb_data_i(cdb_data),
    .flush_i(flush), .busy_count_o(busy_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             rst_n;
    logic             iv;
    int               idst, itag;
    logic             cv;
    int               ctag, cdata;
    logic             fl;
    int               ra, rb;
    int               eda, eta, edb, etb, ebusy;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input int act, input int exp);
    cmp_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [TAG_W-1:0] nt [NUM_REGS];
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin m_data[r] = '0; m_tag[r] = '0; end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) nt[r] = m_tag[r];
      for (int r = 1; r < NUM_REGS; r++)
        if (cdb_valid && cdb_tag != 0 && m_tag[r] == cdb_tag) begin
          m_data[r] = cdb_data;
          nt[r] = '0;
        end
      if (flush) for (int r = 0; r < NUM_REGS; r++) nt[r] = '0;
      else if (issue_valid && issue_dst != 0 && issue_tag != 0) nt[issue_dst] = issue_tag;
      for (int r = 0; r < NUM_REGS; r++) m_tag[r] = nt[r];
    end
    m_busy = 0;
    for (int r = 0; r < NUM_REGS; r++) if (m_tag[r] != 0) m_busy++;
  endtask

  task automatic model_read(input int addr, output int d, output int t);
    d = (addr == 0) ? 0 : int'(m_data[addr]);
    t = (addr == 0) ? 0 : int'(m_tag[addr]);
`ifdef CDB_BYPASS_EN
    if (cdb_valid && cdb_tag != 0 && t == int'(cdb_tag)) begin
      d = int'(cdb_data);
      t = 0;
    end
`endif
  endtask

  task automatic idle();
    rst_n = 1'b1; issue_valid = 1'b0; issue_dst = '0; issue_tag = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic vec_t mk(logic r, logic iv, int idst, int itag, logic cv, int ctag, int cdata,
                              logic fl, int ra, int rb, int eda, int eta, int edb, int etb, int eb);
    vec_t v;
    v.rst_n = r; v.iv = iv; v.idst = idst; v.itag = itag; v.cv = cv; v.ctag = ctag; v.cdata = cdata;
    v.fl = fl; v.ra = ra; v.rb = rb; v.eda = eda; v.eta = eta; v.edb = edb; v.etb = etb; v.ebusy = eb;
    return v;
  endfunction

  initial begin
    int ed, et;
    idle();
    rst_n = 1'b0;
    rd_addr_a = '0; rd_addr_b = '0;

    //            rst iv dst tag cv ctag cdata   fl ra rb  eda     eta edb     etb busy
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 'h0000, 0, 3, 0, 0,      0, 0,      0, 0);
    vecs[1]  = mk(1, 1, 3, 5, 0, 0, 'h0000, 0, 3, 4, 0,      5, 0,      0, 1);
    vecs[2]  = mk(1, 0, 0, 0, 1, 5, 'h00AA, 0, 3, 0, 'h00AA, 0, 0,      0, 0);
    vecs[3]  = mk(1, 1, 4, 6, 0, 0, 'h0000, 0, 4, 3, 0,      6, 'h00AA, 0, 1);
    vecs[4]  = mk(1, 1, 4, 2, 1, 6, 'h1234, 0, 4, 3, 'h1234, 2, 'h00AA, 0, 1);
    vecs[5]  = mk(1, 1, 1, 7, 0, 0, 'h0000, 0, 1, 4, 0,      7, 'h1234, 2, 2);
    vecs[6]  = mk(1, 1, 2, 7, 0, 0, 'h0000, 0, 2, 1, 0,      7, 0,      7, 3);
    vecs[7]  = mk(1, 0, 0, 0, 1, 7, 'hBEEF, 0, 1, 2, 'hBEEF, 0, 'hBEEF, 0, 1);
    vecs[8]  = mk(1, 1, 0, 3, 0, 0, 'h0000, 0, 0, 4, 0,      0, 'h1234, 2, 1);
    vecs[9]  = mk(1, 1, 5, 0, 0, 0, 'h0000, 0, 5, 0, 0,      0, 0,      0, 1);
    vecs[10] = mk(1, 1, 5, 3, 0, 0, 'h0000, 0, 5, 4, 0,      3, 'h1234, 2, 2);
    vecs[11] = mk(1, 1, 6, 1, 0, 0, 'h0000, 0, 6, 5, 0,      1, 0,      3, 3);
    vecs[12] = mk(1, 1, 7, 4, 0, 0, 'h0000, 0, 7, 6, 0,      4, 0,      1, 4);
    vecs[13] = mk(1, 1, 1, 5, 0, 0, 'h0000, 1, 1, 4, 'hBEEF, 0, 'h1234, 0, 0);
    vecs[14] = mk(1, 0, 0, 0, 1, 0, 'hFFFF, 0, 3, 7, 'h00AA, 0, 0,      0, 0);
    vecs[15] = mk(0, 1, 3, 1, 0, 0, 'h0000, 0, 3, 4, 0,      0, 0,      0, 0);

    for (int i = 0; i < 16; i++) begin
      rst_n = vecs[i].rst_n; issue_valid = vecs[i].iv;
      issue_dst = ADDR_W'(vecs[i].idst); issue_tag = TAG_W'(vecs[i].itag);
      cdb_valid = vecs[i].cv; cdb_tag = TAG_W'(vecs[i].ctag); cdb_data = DATA_W'(vecs[i].cdata);
      flush = vecs[i].fl;
      tick();
      idle();
      rd_addr_a = ADDR_W'(vecs[i].ra); rd_addr_b = ADDR_W'(vecs[i].rb);
      #1;
      check($sformatf("vec%0d data_a", i), int'(rd_data_a), vecs[i].eda);
      check($sformatf("vec%0d tag_a", i), int'(rd_tag_a), vecs[i].eta);
      check($sformatf("vec%0d data_b", i), int'(rd_data_b), vecs[i].edb);
      check($sformatf("vec%0d tag_b", i), int'(rd_tag_b), vecs[i].etb);
      check($sformatf("vec%0d busy", i), int'(busy_count), vecs[i].ebusy);
      $display("vec %0d: rd_a=0x%h/%0d rd_b=0x%h/%0d busy=%0d", i, rd_data_a, rd_tag_a,
               rd_data_b, rd_tag_b, busy_count);
    end

    // Bypass window: reg 6 tagged 4, then broadcast tag 4 and look in the same cycle.
    issue_valid = 1'b1; issue_dst = 3'd6; issue_tag = 3'd4;
    tick();
    idle();
    cdb_valid = 1'b1; cdb_tag = 3'd4; cdb_data = 16'h0F0F; rd_addr_b = 3'd6; rd_addr_a = 3'd6;
    #1;
`ifdef CDB_BYPASS_EN
    check("bypass same-cycle data_b", int'(rd_data_b), 'h0F0F);
    check("bypass same-cycle tag_b", int'(rd_tag_b), 0);
`else
    check("nobypass same-cycle data_b", int'(rd_data_b), 0);
    check("nobypass same-cycle tag_b", int'(rd_tag_b), 4);
`endif
    check("same-cycle busy", int'(busy_count), 1);
    tick();
    idle();
    #1;
    check("after-cdb data_b", int'(rd_data_b), 'h0F0F);
    check("after-cdb tag_b", int'(rd_tag_b), 0);
    check("after-cdb busy", int'(busy_count), 0);
    $display("bypass seq: rd_b=0x%h/%0d busy=%0d", rd_data_b, rd_tag_b, busy_count);

    // Flush together with a retiring CDB: data still lands, tags all clear.
    issue_valid = 1'b1; issue_dst = 3'd2; issue_tag = 3'd3;
    tick();
    idle();
    issue_valid = 1'b1; issue_dst = 3'd5; issue_tag = 3'd6;
    tick();
    idle();
    flush = 1'b1; cdb_valid = 1'b1; cdb_tag = 3'd3; cdb_data = 16'h5555;
    issue_valid = 1'b1; issue_dst = 3'd7; issue_tag = 3'd1;
    tick();
    idle();
    rd_addr_a = 3'd2; rd_addr_b = 3'd7;
    #1;
    check("flush+cdb data_a", int'(rd_data_a), 'h5555);
    check("flush+cdb tag_a", int'(rd_tag_a), 0);
    check("flush+issue tag_b", int'(rd_tag_b), 0);
    check("flush busy", int'(busy_count), 0);
    $display("flush seq: rd_a=0x%h/%0d rd_b tag=%0d busy=%0d", rd_data_a, rd_tag_a, rd_tag_b, busy_count);

    // Random phase against the model; reads are checked with CDB inputs live.
    for (int n = 0; n < 600; n++) begin
      rst_n       = ($urandom_range(0, 99) != 0);
      issue_valid = ($urandom_range(0, 99) < 60);
      issue_dst   = ADDR_W'($urandom_range(0, NUM_REGS - 1));
      issue_tag   = TAG_W'($urandom_range(0, 7));
      cdb_valid   = ($urandom_range(0, 99) < 60);
      cdb_tag     = TAG_W'($urandom_range(0, 7));
      cdb_data    = DATA_W'($urandom);
      flush       = ($urandom_range(0, 99) < 4);
      rd_addr_a   = ADDR_W'($urandom_range(0, NUM_REGS - 1));
      rd_addr_b   = ADDR_W'($urandom_range(0, NUM_REGS - 1));
      #1;
      model_read(int'(rd_addr_a), ed, et);
      check("rand data_a", int'(rd_data_a), ed);
      check("rand tag_a", int'(rd_tag_a), et);
      model_read(int'(rd_addr_b), ed, et);
      check("rand data_b", int'(rd_data_b), ed);
      check("rand tag_b", int'(rd_tag_b), et);
      tick();
      check("rand busy", int'(busy_count), m_busy);
      if (n % 100 == 0)
        $display("rand %0d: busy=%0d model=%0d", n, busy_count, m_busy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
